apb_reg_slave: RTL

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_pkg.sv | 27 ++
 rtl/apb_reg_bank.sv | 42 ++++
 rtl/apb_reg_slave.sv | 132 +++++++++++++
 3 files changed

// File: rtl/apb_reg_pkg.sv
// Shared types, constants and address-decode helper for the APB register slave.
package apb_reg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int REG_BYTES = 4;

  // Misaligned, out-of-range, or a write to the read-only status word (last index).
  function automatic logic decode_err(input logic [63:0] addr, input logic is_write,
                                      input int num_regs);
    logic [63:0] limit_s;
    limit_s = 64'(num_regs) * 64'(REG_BYTES);
    if (addr[1:0] != 2'b00) begin
      return 1'b1;
    end else if (addr >= limit_s) begin
      return 1'b1;
    end else if (is_write && (addr == (limit_s - 64'(REG_BYTES)))) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array with byte-lane strobed writes, one read port, and a flat view.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IW       = 4
) (
  input  logic                     clk,
  input  logic                     sys_reset,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [REG_BYTES-1:0]     wr_strb,
  input  logic [IW-1:0]            rd_idx,
  output logic [31:0]              rd_data,
  output logic [NUM_REGS*32-1:0]   regs
);

  logic [31:0] mem_r [NUM_REGS];

  // Register storage: clear on reset, update strobed lanes on write.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en) begin
      for (int b = 0; b < REG_BYTES; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem_r[rd_idx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*32 +: 32] = mem_r[g];
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: setup capture, programmable wait states, decode and error response.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int AW_APB      = 32,
  parameter int DW_APB      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       apb_clk,
  input  logic                       sys_reset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [AW_APB-1:0]          paddr,
  input  logic [DW_APB-1:0]          pwdata,
  input  logic [DW_APB/8-1:0]        pstrb,
  output logic [DW_APB-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [DW_APB-1:0]          status_in,
  output logic [NUM_REGS*DW_APB-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int IW = $clog2(NUM_REGS);

  apb_state_e            state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  logic [AW_APB-1:0]     paddr_r;
  logic                  pwrite_r;
  logic [DW_APB-1:0]     pwdata_r;
  logic [DW_APB/8-1:0]   pstrb_r;
  logic                  setup_s, done_s, err_s, wr_en_s;
  logic [IW-1:0]         idx_s;
  logic [DW_APB-1:0]     bank_rd_s, rd_word_s;
  logic [NUM_REGS-1:0]   one_hot_s, wr_pulse_r;

  // Next-state and wait-counter logic; done_s marks the completing cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    setup_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (psel && !penable) begin
          setup_s     = 1'b1;
          cnt_nxt_s   = 4'(WAIT_CYCLES);
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_nxt_s = ST_IDLE;
        end else if (penable) begin
          if (cnt_r == 4'd0) begin
            done_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, captured transfer and write-pulse registers.
  always_ff @(posedge apb_clk) begin
    if (sys_reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      paddr_r    <= {AW_APB{1'b0}};
      pwrite_r   <= 1'b0;
      pwdata_r   <= {DW_APB{1'b0}};
      pstrb_r    <= {(DW_APB/8){1'b0}};
      wr_pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (setup_s) begin
        paddr_r  <= paddr;
        pwrite_r <= pwrite;
        pwdata_r <= pwdata;
        pstrb_r  <= pstrb;
      end
      wr_pulse_r <= wr_en_s ? one_hot_s : {NUM_REGS{1'b0}};
    end
  end

  assign idx_s     = paddr_r[IW+1:2];
  assign err_s     = decode_err(64'(paddr_r), pwrite_r, NUM_REGS);
  assign wr_en_s   = done_s & pwrite_r & ~err_s;
  assign one_hot_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx_s;
  assign rd_word_s = (idx_s == IW'(NUM_REGS - 1)) ? status_in : bank_rd_s;

  // Read data is driven only while a legal read completes.
  always_comb begin
    if (done_s && !pwrite_r && !err_s) begin
      prdata = rd_word_s;
    end else begin
      prdata = {DW_APB{1'b0}};
    end
  end

  assign pready   = done_s;
  assign pslverr  = done_s & err_s;
  assign wr_pulse = wr_pulse_r;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_bank (
    .clk       (apb_clk),
    .sys_reset (sys_reset),
    .wr_en     (wr_en_s),
    .wr_idx    (idx_s),
    .wr_data   (pwdata_r),
    .wr_strb   (pstrb_r),
    .rd_idx    (idx_s),
    .rd_data   (bank_rd_s),
    .regs      (reg_out)
  );

endmodule
